io_port_bank: RTL
=================

# io_port_bank

Parametrised I/O port bank for the single-cycle CPU family. It generalises the fixed four-in/four-out 8-bit port scheme to NPORTS channels of WIDTH bits. It adds:
- input synchronisation;
- per-channel change detection with maskable, prioritised interrupt request;
- write strobes on output ports.

It sits between the datapath's port-select/write-enable signals and the chip pins.

## Interface
Parameters:
- WIDTH, 8, data width of every port
- NPORTS, 4, number of input and output channels (2..16)
- ADDRW, max(1, clog2(NPORTS)), port-select width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- addr  in  ADDRW  port select for read, write and clear
- we  in  1  write wdata to output port addr
- wdata  in  WIDTH  output write data
- re  in  1  CPU read of input port addr; clears that port's pending flag
- rdata  out  WIDTH  synchronised value of input port addr (combinational from registers)
- ie_we  in  1  load interrupt-enable mask
- ie_wdata  in  NPORTS  new interrupt-enable mask
- irq_ack  in  1  clears pending flag of current irq_id
- iport  in  NPORTS*WIDTH  raw asynchronous inputs, channel i at bits [i*WIDTH +: WIDTH]
- oport  out  NPORTS*WIDTH  registered outputs, same packing
- ostb  out  NPORTS  one-cycle strobe, high in the cycle the new oport value first appears
- irq  out  1  OR of (pending & ien)
- irq_id  out  ADDRW  lowest index i with pending[i] & ien[i]; 0 when irq low

## Operation
- **Reset values:** oport = 0, ostb = 0, ien = 0, pending = 0, sync/prev registers = 0, warm-up counter = 0. Therefore rdata = 0, irq = 0 and irq_id = 0 during and right after reset.
- **Input path per channel:** s1 <= iport_i; s2 <= s1; prev <= s2. rdata = s2[addr].
- **Change detect:**
  - change_i = (s2 != prev) && warm == 3.
  - warm is a 2-bit saturating counter, 0->1->2->3, one step per edge after reset release. It suppresses false changes from reset-zeroed registers.
- **Pending update per channel each edge:**
  - set if change_i;
  - else clear if (re && addr == i) or (irq_ack && irq && irq_id == i);
  - else hold.
  - Set wins over simultaneous clear, so no event is lost.
- **Interrupt:**
  - irq and irq_id are combinational from the pending and ien registers; the lowest index has priority.
  - irq_ack while irq = 0 has no effect.
  - ien changes affect irq in the cycle after the ie_we edge. Pending flags are latched regardless of ien.
- **Output path:**
  - on we, oport[addr] <= wdata and ostb[addr] <= 1; all other ostb bits <= 0.
  - without we, ostb <= 0.
  - Back-to-back writes to the same port produce ostb high on consecutive cycles.
- **Concurrency:** we, re, ie_we and irq_ack may all be asserted in the same cycle; each acts independently.
- **Addressing:** addr >= NPORTS means write ignored, no strobe, rdata = 0, no clear.
- **Reset mid-operation:** everything returns to reset values asynchronously and warm restarts at 0.

## Timing
- Input change settling before edge E:
  - s1 updates at E;
  - rdata shows the new value after E+1;
  - pending and irq assert after E+2.
- Write at edge W: oport and ostb valid after W; ostb deasserts after W+1 unless rewritten.
- Read-clear or ack at edge C: pending low after C, so irq drops or irq_id advances after C.
- Warm-up: no change detection on the first three edges after reset release.
- No combinational path from iport to any output.

## Structure
- Package io_pkg:
  - default WIDTH/NPORTS constants;
  - the warm-up terminal count (3);
  - a lowest-set-bit priority-encoder function returning index and valid, used for irq_id.
- Sub-module io_in_chan, instantiated NPORTS times via generate. It holds s1/s2/prev, the compare, and the pending flag with set-over-clear logic. Its inputs are clk, reset, din, detect_en, clr; its outputs are sync value and pending.
- The top level holds:
  - the warm-up counter;
  - the ien register;
  - the output registers and strobes;
  - the rdata mux and the priority encoder.

## Test plan
- **Reset and warm-up:** hold iport = 0xA5 on all channels through reset release, ien = 0xF.
  - Expect rdata = 0xA5 on each addr by edge 2, irq never asserts, oport = 0, ostb = 0.
- **Change -> irq -> read-clear:**
  - ien = 0b0101; toggle channel 2 to 0x3C at edge E. Expect irq = 1, irq_id = 2 after E+2.
  - re with addr = 2 at the next edge. Expect irq = 0 the following cycle and rdata = 0x3C.
- **Priority and ack:**
  - channels 3 and 1 change on the same edge, ien = 0xF. Expect irq_id = 1.
  - irq_ack -> irq_id = 3; second irq_ack -> irq = 0.
- **Set-wins:**
  - channel 0 pending; re with addr = 0 on the same edge a new change is detected on channel 0. Expect pending to stay 1 (irq still high, irq_id = 0).
- **Output writes:**
  - we addr = 1 wdata = 0x7E, then addr = 1 wdata = 0x81 on consecutive edges. Expect oport ch1 = 0x7E then 0x81 and ostb = 0b0010 for two cycles, then 0.
  - With NPORTS = 3, addr = 3 is ignored.
- **Async reset mid-operation:** assert reset (0) while irq = 1 and ostb active.
  - Expect irq, ostb, oport and rdata all 0 before the next clk edge.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and lowest-index priority encoder for io_port_bank
package io_pkg;

  localparam int         DEF_WIDTH  = 8;
  localparam int         DEF_NPORTS = 4;
  localparam int         MAX_NPORTS = 16;
  localparam logic [1:0] WARM_TC    = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } penc_t;

  // Scans from the top down so the last hit, the lowest set index, wins.
  function automatic penc_t lowest_set(input logic [MAX_NPORTS-1:0] req);
    penc_t r;
    r = '0;
    for (int i = MAX_NPORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/io_in_chan.sv
// rtl/io_in_chan.sv - one input channel: two-flop synchroniser, change compare, pending flag
module io_in_chan
  import io_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             detect_en,
  input  logic             clr,
  output logic [WIDTH-1:0] sync,
  output logic             pending
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] prev;
  logic             change;

  assign change = detect_en && (s2 != prev);
  assign sync   = s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      pending <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      // A fresh change beats a simultaneous clear so no event is dropped.
      if (change) begin
        pending <= 1'b1;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - NPORTS x WIDTH I/O port bank with change interrupts and write strobes
module io_port_bank
  import io_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NPORTS = DEF_NPORTS,
  localparam int ADDRW  = (NPORTS > 2) ? $clog2(NPORTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRW-1:0]        addr,
  input  logic                    we,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    re,
  output logic [WIDTH-1:0]        rdata,
  input  logic                    ie_we,
  input  logic [NPORTS-1:0]       ie_wdata,
  input  logic                    irq_ack,
  input  logic [NPORTS*WIDTH-1:0] iport,
  output logic [NPORTS*WIDTH-1:0] oport,
  output logic [NPORTS-1:0]       ostb,
  output logic                    irq,
  output logic [ADDRW-1:0]        irq_id
);

  logic [1:0]        warm;
  logic              detect_en;
  logic [NPORTS-1:0] ien;
  logic [NPORTS-1:0] pending;
  logic [NPORTS-1:0] clr;
  logic [WIDTH-1:0]  sync_val [NPORTS];
  penc_t             penc;

  // Reset-zeroed sync/prev registers would look like a change; hold detection off until they fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm <= 2'd0;
    end else if (warm != WARM_TC) begin
      warm <= warm + 2'd1;
    end
  end

  assign detect_en = (warm == WARM_TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ien <= '0;
    end else if (ie_we) begin
      ien <= ie_wdata;
    end
  end

  assign penc   = lowest_set(MAX_NPORTS'(pending & ien));
  assign irq    = penc.valid;
  assign irq_id = ADDRW'(penc.idx);

  for (genvar g = 0; g < NPORTS; g++) begin : g_chan
    assign clr[g] = (re && (addr == ADDRW'(g))) ||
                    (irq_ack && irq && (irq_id == ADDRW'(g)));

    io_in_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .din       (iport[g*WIDTH +: WIDTH]),
      .detect_en (detect_en),
      .clr       (clr[g]),
      .sync      (sync_val[g]),
      .pending   (pending[g])
    );
  end

  // Addresses past the last channel match nothing and read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (addr == ADDRW'(i)) begin
        rdata = sync_val[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oport <= '0;
      ostb  <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        ostb[i] <= we && (addr == ADDRW'(i));
        if (we && (addr == ADDRW'(i))) begin
          oport[i*WIDTH +: WIDTH] <= wdata;
        end
      end
    end
  end

endmodule
